// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encodings and
// the iteration counter width helper.
package mul_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int count_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/n_bit_adder.sv
// Plain n-bit ripple-carry adder with no carry in and no carry out; used as
// the single shared partial-sum adder of the multiplier.
module n_bit_adder #(
    parameter int n = 16
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    output logic [n-1:0] sum
);

    // A scalar carry walked through the loop keeps the chain free of
    // combinational self-reference on a vector.
    always_comb begin
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < n; i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN -> 2N multiplier, one partial product per cycle.
// Optional macro MUL_EARLY_TERM_EN ends RUN once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | one shift-add step per cycle through the shared adder
// DONE  | one-cycle done pulse; a new start here is accepted back-to-back
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int              CW         = count_width(N);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(N - 1);

    logic [1:0]     state;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  count;
    logic [2*N-1:0] addend;
    logic [2*N-1:0] acc_next;
    logic           load;
    logic           last_step;

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign load  = start && ready;

    assign addend = mplier[0] ? mcand : '0;

    n_bit_adder #(.n(2 * N)) u_adder (
        .x   (acc),
        .y   (addend),
        .sum (acc_next)
    );

`ifdef MUL_EARLY_TERM_EN
    // Stop as soon as no set multiplier bits remain after this step.
    assign last_step = (count == LAST_COUNT) || (mplier[N-1:1] == '0);
`else
    assign last_step = (count == LAST_COUNT);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= start ? RUN : IDLE;
                RUN:     state <= last_step ? DONE : RUN;
                DONE:    state <= start ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            count  <= '0;
        end else if (state == RUN) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (last_step) begin
                product <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (N=8); build with MUL_EARLY_TERM_EN
// defined to exercise the early-termination latencies.
module tb_shift_add_multiplier;

    localparam int N = 8;

    logic           clk;
    logic           reset;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_tests;
    int n_fail;

    shift_add_multiplier #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] prod;
    } vec_t;

    vec_t vecs[10];

    function automatic int exp_runs(input logic [N-1:0] bv);
        int r;
        r = N;
`ifdef MUL_EARLY_TERM_EN
        r = 1;
        for (int i = 0; i < N; i++) if (bv[i]) r = i + 1;
`endif
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one edge, then scrambles the operands to show they were captured.
    task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            cyc++;
        end
        if (cyc >= 40) check("done_timeout", cyc, -1);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int cyc, bc, runs;
        runs = exp_runs(v.b);
        start_op(v.a, v.b);
        wait_done(cyc, bc);
        check({name, "_latency"}, cyc + 1, runs + 1);
        check({name, "_busy_cycles"}, bc, runs);
        check({name, "_product"}, product, v.prod);
        check({name, "_ready_at_done"}, ready, 1);
        step();
        check({name, "_done_pulse_width"}, done, 0);
        step();
        check({name, "_product_hold"}, product, v.prod);
    endtask

    initial begin
        int cyc, bc, pre;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd0,   8'd200, 16'd0};
        vecs[3] = '{8'd77,  8'd0,   16'd0};
        vecs[4] = '{8'd3,   8'd1,   16'd3};
        vecs[5] = '{8'd1,   8'd255, 16'd255};
        vecs[6] = '{8'd128, 8'd2,   16'd256};
        vecs[7] = '{8'd200, 8'd3,   16'd600};
        vecs[8] = '{8'd255, 8'd128, 16'd32640};
        vecs[9] = '{8'd170, 8'd85,  16'd14450};

        step();
        step();
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Start pulsed mid-run is ignored; start in DONE is taken back-to-back.
        start_op(8'd5, 8'd6);
        step();
        step();
        check("midrun_busy", busy, 1);
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(cyc, bc);
        check("ignored_start_latency", cyc + 3, exp_runs(8'd6));
        check("ignored_start_product", product, 30);
        start_op(8'd9, 8'd9);
        check("b2b_accepted_busy", busy, 1);
        check("b2b_accepted_ready", ready, 0);
        wait_done(cyc, bc);
        check("b2b_latency", cyc + 1, exp_runs(8'd9) + 1);
        check("b2b_product", product, 81);
        step();

        // Reset in the middle of RUN aborts and clears the result.
        start_op(8'd100, 8'd100);
        step();
        step();
        step();
        pre = busy;
        check("abort_pre_busy", pre, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", ready, 1);
        check("abort_product", product, 0);
        step();
        run_vec("after_abort", '{8'd3, 8'd7, 16'd21});

        // Start and reset together: reset wins.
        a     = 8'd4;
        b     = 8'd4;
        start = 1'b1;
        reset = 1'b1;
        step();
        start = 1'b0;
        reset = 1'b0;
        check("start_reset_busy", busy, 0);
        check("start_reset_product", product, 0);
        step();
        check("start_reset_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
